// File: rtl/mem_port_arbiter.sv
// Backing-memory port arbiter: round-robin between I-refill and D-refill/write-back,
// with grant-time latching of the request and a BUSY watchdog abort.
module mem_port_arbiter #(
  parameter int pAddrWidth = 32,
  parameter int pBlockBits = 256,
  parameter int pTimeout   = 63
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  i_req_i,
  input  logic [pAddrWidth-1:0] i_addr_i,
  output logic                  i_ack_o,
  output logic                  i_err_o,
  output logic [pBlockBits-1:0] i_data_o,
  input  logic                  d_req_i,
  input  logic                  d_write_ctrl_i,
  input  logic [pAddrWidth-1:0] d_addr_i,
  input  logic [pBlockBits-1:0] d_write_data_i,
  output logic                  d_ack_o,
  output logic                  d_err_o,
  output logic [pBlockBits-1:0] d_data_o,
  output logic                  mem_enable_o,
  output logic                  mem_write_ctrl_o,
  output logic [pAddrWidth-1:0] mem_addr_o,
  output logic [pBlockBits-1:0] mem_write_data_o,
  input  logic                  mem_ack_i,
  input  logic [pBlockBits-1:0] mem_read_data_i,
  output logic                  busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RESP_I,
    RESP_D
  } state_e;

  localparam logic [7:0] TmoLast = 8'(pTimeout - 1);

  state_e                state_q, state_d;
  logic                  last_d_q, last_d_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [pAddrWidth-1:0] addr_q, addr_d;
  logic [pBlockBits-1:0] wdata_q, wdata_d;
  logic                  wctrl_q, wctrl_d;
  logic [pBlockBits-1:0] idata_q, idata_d;
  logic [pBlockBits-1:0] ddata_q, ddata_d;
  logic                  ierr_q, ierr_d;
  logic                  derr_q, derr_d;
  logic                  sel_d;
  logic                  hit_tmo;

  // D wins when alone, or on contention when I had the previous grant.
  assign sel_d   = d_req_i & (~i_req_i | ~last_d_q);
  assign hit_tmo = (cnt_q == TmoLast);

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wctrl_d  = wctrl_q;
    idata_d  = idata_q;
    ddata_d  = ddata_q;
    ierr_d   = ierr_q;
    derr_d   = derr_q;
    unique case (state_q)
      IDLE: begin
        if (i_req_i | d_req_i) begin
          state_d  = sel_d ? BUSY_D : BUSY_I;
          last_d_d = sel_d;
          cnt_d    = '0;
          addr_d   = sel_d ? d_addr_i : i_addr_i;
          wctrl_d  = sel_d & d_write_ctrl_i;
          wdata_d  = sel_d ? d_write_data_i : '0;
        end
      end
      BUSY_I: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_ack_i) begin
          idata_d = mem_read_data_i;
          ierr_d  = 1'b0;
          state_d = RESP_I;
        end else if (hit_tmo) begin
          idata_d = '0;
          ierr_d  = 1'b1;
          state_d = RESP_I;
        end
      end
      BUSY_D: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_ack_i) begin
          ddata_d = mem_read_data_i;
          derr_d  = 1'b0;
          state_d = RESP_D;
        end else if (hit_tmo) begin
          ddata_d = '0;
          derr_d  = 1'b1;
          state_d = RESP_D;
        end
      end
      RESP_I, RESP_D: state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wctrl_q  <= 1'b0;
      idata_q  <= '0;
      ddata_q  <= '0;
      ierr_q   <= 1'b0;
      derr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wctrl_q  <= wctrl_d;
      idata_q  <= idata_d;
      ddata_q  <= ddata_d;
      ierr_q   <= ierr_d;
      derr_q   <= derr_d;
    end
  end

  assign busy_o           = (state_q != IDLE);
  assign mem_enable_o     = (state_q == BUSY_I) | (state_q == BUSY_D);
  assign mem_write_ctrl_o = wctrl_q;
  assign mem_addr_o       = addr_q;
  assign mem_write_data_o = wdata_q;
  assign i_ack_o          = (state_q == RESP_I);
  assign d_ack_o          = (state_q == RESP_D);
  assign i_err_o          = i_ack_o & ierr_q;
  assign d_err_o          = d_ack_o & derr_q;
  assign i_data_o         = idata_q;
  assign d_data_o         = ddata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scenario bench for mem_port_arbiter: expected completions are queued at
// request time and matched against each ack pulse by a monitor.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int BW = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i;
  logic          i_req_i, d_req_i, d_write_ctrl_i;
  logic [AW-1:0] i_addr_i, d_addr_i;
  logic [BW-1:0] d_write_data_i;
  logic          i_ack_o, i_err_o, d_ack_o, d_err_o;
  logic [BW-1:0] i_data_o, d_data_o;
  logic          mem_enable_o, mem_write_ctrl_o, busy_o;
  logic [AW-1:0] mem_addr_o;
  logic [BW-1:0] mem_write_data_o;
  logic          mem_ack_i;
  logic [BW-1:0] mem_read_data_i;

  logic          resp_ack = 1'b0;
  logic          stray_ack;
  logic          mem_silent;
  logic          use_addr;
  int            mem_lat;
  logic [BW-1:0] mem_rdata;
  int            en_cnt = 0;

  int tests_run = 0;
  int fails = 0;

  typedef struct packed {
    logic          side;
    logic          err;
    logic [BW-1:0] data;
  } exp_t;
  exp_t sb[$];

  mem_port_arbiter #(
    .pAddrWidth(AW),
    .pBlockBits(BW),
    .pTimeout  (8)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .i_req_i         (i_req_i),
    .i_addr_i        (i_addr_i),
    .i_ack_o         (i_ack_o),
    .i_err_o         (i_err_o),
    .i_data_o        (i_data_o),
    .d_req_i         (d_req_i),
    .d_write_ctrl_i  (d_write_ctrl_i),
    .d_addr_i        (d_addr_i),
    .d_write_data_i  (d_write_data_i),
    .d_ack_o         (d_ack_o),
    .d_err_o         (d_err_o),
    .d_data_o        (d_data_o),
    .mem_enable_o    (mem_enable_o),
    .mem_write_ctrl_o(mem_write_ctrl_o),
    .mem_addr_o      (mem_addr_o),
    .mem_write_data_o(mem_write_data_o),
    .mem_ack_i       (mem_ack_i),
    .mem_read_data_i (mem_read_data_i),
    .busy_o          (busy_o)
  );

  assign mem_ack_i       = resp_ack | stray_ack;
  assign mem_read_data_i = use_addr ? {8{mem_addr_o}} : mem_rdata;

  // Memory model: acks on the mem_lat-th consecutive enable cycle.
  always begin
    @(posedge clk);
    #1;
    if (mem_enable_o && !mem_silent) en_cnt++;
    else en_cnt = 0;
    resp_ack = mem_enable_o && !mem_silent && (en_cnt == mem_lat);
  end

  always @(negedge clk) begin
    exp_t e, g;
    if (!rst_i && (i_ack_o || d_ack_o)) begin
      tests_run++;
      g.side = d_ack_o;
      g.err  = d_ack_o ? d_err_o : i_err_o;
      g.data = d_ack_o ? d_data_o : i_data_o;
      if (i_ack_o && d_ack_o) begin
        fails++;
        $display("FAIL ack_overlap: i_ack=%b d_ack=%b, required one", i_ack_o, d_ack_o);
      end else if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_ack: side=%0d, required no ack", g.side);
      end else begin
        e = sb.pop_front();
        if (g !== e) begin
          fails++;
          $display("FAIL completion: side=%0d err=%b data=%h, required side=%0d err=%b data=%h",
                   g.side, g.err, g.data, e.side, e.err, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic exp_t mk(logic side, logic err, logic [BW-1:0] data);
    exp_t e;
    e.side = side;
    e.err  = err;
    e.data = data;
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    i_req_i = 0; d_req_i = 0; d_write_ctrl_i = 0;
    i_addr_i = '0; d_addr_i = '0; d_write_data_i = '0;
    stray_ack = 0; mem_silent = 1; use_addr = 0; mem_lat = 1; mem_rdata = '0;
    #2;
    tests_run++;
    if ({busy_o, mem_enable_o, mem_write_ctrl_o, i_ack_o, d_ack_o, i_err_o, d_err_o} !== 7'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b, required 0000000",
               {busy_o, mem_enable_o, mem_write_ctrl_o, i_ack_o, d_ack_o, i_err_o, d_err_o});
    end
    tests_run++;
    if ({mem_addr_o, mem_write_data_o, i_data_o, d_data_o} !== '0) begin
      fails++;
      $display("FAIL reset_buses: addr=%h wdata=%h, required 0", mem_addr_o, mem_write_data_o);
    end
    cyc();
    rst_i = 1'b0;
    cyc();
    tests_run++;
    if (busy_o !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: busy=%b, required 0", busy_o);
    end
  endtask

  task automatic test_contention();
    int acks, overlap;
    acks = 0; overlap = 0;
    mem_silent = 0; use_addr = 1; mem_lat = 2;
    i_addr_i = 32'h100; d_addr_i = 32'h200; d_write_ctrl_i = 0;
    sb.push_back(mk(1'b1, 1'b0, {8{32'h200}}));
    sb.push_back(mk(1'b0, 1'b0, {8{32'h100}}));
    sb.push_back(mk(1'b1, 1'b0, {8{32'h200}}));
    sb.push_back(mk(1'b0, 1'b0, {8{32'h100}}));
    i_req_i = 1; d_req_i = 1;
    for (int k = 0; k < 60 && acks < 4; k++) begin
      cyc();
      if (i_ack_o || d_ack_o) begin
        acks++;
        if (mem_enable_o) overlap++;
        if (acks == 4) begin
          i_req_i = 0; d_req_i = 0;
        end
      end
    end
    i_req_i = 0; d_req_i = 0;
    tests_run++;
    if (acks !== 4) begin
      fails++;
      $display("FAIL contention_acks: got %0d, required 4", acks);
    end
    tests_run++;
    if (overlap !== 0) begin
      fails++;
      $display("FAIL contention_enable_gap: enable high in %0d ack cycles, required 0", overlap);
    end
    cyc();
    cyc();
    tests_run++;
    if (busy_o !== 1'b0) begin
      fails++;
      $display("FAIL contention_idle: busy=%b, required 0", busy_o);
    end
    use_addr = 0;
  endtask

  task automatic test_single_i();
    int en, bad;
    logic got, saw_d;
    en = 0; bad = 0; got = 0; saw_d = 0;
    mem_silent = 0; mem_lat = 5; mem_rdata = {32{8'hA5}};
    i_addr_i = 32'h40;
    sb.push_back(mk(1'b0, 1'b0, {32{8'hA5}}));
    i_req_i = 1;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (mem_enable_o) begin
        en++;
        if (mem_write_ctrl_o !== 1'b0 || mem_addr_o !== 32'h40) bad++;
      end
      if (d_ack_o) saw_d = 1;
      if (i_ack_o) begin
        got = 1;
        break;
      end
    end
    tests_run++;
    if (got !== 1'b1 || en !== 5) begin
      fails++;
      $display("FAIL single_i_latency: ack=%b enable_cycles=%0d, required 1 and 5", got, en);
    end
    tests_run++;
    if (bad !== 0 || saw_d !== 1'b0 || i_err_o !== 1'b0) begin
      fails++;
      $display("FAIL single_i_ctrl: bad=%0d d_ack_seen=%b err=%b, required 0 0 0", bad, saw_d, i_err_o);
    end
    i_req_i = 0;
    cyc();
    tests_run++;
    if (i_ack_o !== 1'b0 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL single_i_pulse: ack=%b busy=%b, required 0 0", i_ack_o, busy_o);
    end
  endtask

  task automatic test_d_write();
    int en, bad;
    logic got;
    en = 0; bad = 0; got = 0;
    mem_lat = 3; mem_rdata = {32{8'h3C}};
    d_addr_i = 32'h1000; d_write_ctrl_i = 1; d_write_data_i = {8{32'h12345678}};
    sb.push_back(mk(1'b1, 1'b0, {32{8'h3C}}));
    d_req_i = 1;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (mem_enable_o) begin
        en++;
        if (mem_write_ctrl_o !== 1'b1 || mem_addr_o !== 32'h1000 ||
            mem_write_data_o !== {8{32'h12345678}}) bad++;
      end
      if (d_ack_o) begin
        got = 1;
        break;
      end
    end
    tests_run++;
    if (got !== 1'b1 || en !== 3 || bad !== 0) begin
      fails++;
      $display("FAIL d_write: ack=%b enable_cycles=%0d bad=%0d, required 1 3 0", got, en, bad);
    end
    d_req_i = 0; d_write_ctrl_i = 0; d_write_data_i = '0;
    cyc();
  endtask

  task automatic test_addr_change();
    int en, bad;
    logic got;
    en = 0; bad = 0; got = 0;
    mem_lat = 4; mem_rdata = {32{8'h5A}};
    d_addr_i = 32'h20; d_write_ctrl_i = 0; d_write_data_i = '0;
    sb.push_back(mk(1'b1, 1'b0, {32{8'h5A}}));
    d_req_i = 1;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (mem_enable_o) begin
        en++;
        if (mem_addr_o !== 32'h20 || mem_write_ctrl_o !== 1'b0 || mem_write_data_o !== '0) bad++;
        if (en == 1) begin
          d_addr_i = 32'h60; d_write_ctrl_i = 1; d_write_data_i = '1;
        end
      end
      if (d_ack_o) begin
        got = 1;
        break;
      end
    end
    tests_run++;
    if (got !== 1'b1 || bad !== 0 || mem_addr_o !== 32'h20) begin
      fails++;
      $display("FAIL addr_hold: ack=%b bad=%0d addr=%h, required 1 0 00000020", got, bad, mem_addr_o);
    end
    d_req_i = 0; d_write_ctrl_i = 0; d_write_data_i = '0;
    cyc();
  endtask

  task automatic test_timeout();
    int en, at;
    logic got;
    en = 0; at = 0; got = 0;
    mem_silent = 1;
    d_addr_i = 32'h80; d_write_ctrl_i = 0;
    sb.push_back(mk(1'b1, 1'b1, '0));
    d_req_i = 1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (mem_enable_o) en++;
      if (d_ack_o) begin
        at = k;
        break;
      end
    end
    tests_run++;
    if (at !== 9 || en !== 8) begin
      fails++;
      $display("FAIL timeout_latency: ack after %0d edges, enable_cycles=%0d, required 9 and 8", at, en);
    end
    tests_run++;
    if (d_err_o !== 1'b1 || d_data_o !== '0) begin
      fails++;
      $display("FAIL timeout_resp: err=%b data=%h, required 1 and 0", d_err_o, d_data_o);
    end
    d_req_i = 0;
    cyc();
    mem_silent = 0; mem_lat = 2; mem_rdata = {32{8'hC3}};
    i_addr_i = 32'h44;
    sb.push_back(mk(1'b0, 1'b0, {32{8'hC3}}));
    i_req_i = 1;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (i_ack_o) begin
        got = 1;
        break;
      end
    end
    tests_run++;
    if (got !== 1'b1 || i_err_o !== 1'b0) begin
      fails++;
      $display("FAIL after_timeout_i: ack=%b err=%b, required 1 0", got, i_err_o);
    end
    i_req_i = 0;
    cyc();
  endtask

  task automatic test_ack_at_timeout();
    int en;
    logic got;
    en = 0; got = 0;
    mem_silent = 0; mem_lat = 8; mem_rdata = {32{8'h77}};
    i_addr_i = 32'h48;
    sb.push_back(mk(1'b0, 1'b0, {32{8'h77}}));
    i_req_i = 1;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (mem_enable_o) en++;
      if (i_ack_o) begin
        got = 1;
        break;
      end
    end
    tests_run++;
    if (got !== 1'b1 || en !== 8 || i_err_o !== 1'b0) begin
      fails++;
      $display("FAIL ack_wins: ack=%b enable_cycles=%0d err=%b, required 1 8 0", got, en, i_err_o);
    end
    i_req_i = 0;
    cyc();
  endtask

  task automatic test_reset_mid();
    int bad;
    bad = 0;
    mem_silent = 1;
    i_addr_i = 32'h40;
    i_req_i = 1;
    cyc();
    cyc();
    tests_run++;
    if (busy_o !== 1'b1 || mem_enable_o !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_setup: busy=%b en=%b, required 1 1", busy_o, mem_enable_o);
    end
    rst_i = 1;
    i_req_i = 0;
    #2;
    tests_run++;
    if ({busy_o, mem_enable_o, i_ack_o, d_ack_o} !== 4'b0 ||
        mem_addr_o !== '0 || i_data_o !== '0) begin
      fails++;
      $display("FAIL reset_mid_async: busy=%b en=%b addr=%h idata=%h, required all 0",
               busy_o, mem_enable_o, mem_addr_o, i_data_o);
    end
    cyc();
    rst_i = 0;
    stray_ack = 1;
    cyc();
    stray_ack = 0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      if (i_ack_o || d_ack_o || busy_o) bad++;
    end
    tests_run++;
    if (bad !== 0 || i_data_o !== '0) begin
      fails++;
      $display("FAIL reset_mid_late_ack: bad=%0d idata=%h, required 0 and 0", bad, i_data_o);
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_i();
    test_d_write();
    test_addr_change();
    test_timeout();
    test_ack_at_timeout();
    test_reset_mid();
    tests_run++;
    if (sb.size() !== 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d pending, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
